// File: rtl/cache_flush_ctrl_if.sv
// Flush sequencer <-> cache array/bus signal bundle.
// master: the flush controller; slave: the cache side (arrays, bus, requester).
interface cache_flush_ctrl_if #(
   parameter int unsigned NUMWAYS = 4,
   parameter int unsigned SETLEN  = 9
) ();
   logic                FlushReq;
   logic                InvalidateReq;
   logic                Stall;
   logic [NUMWAYS-1:0]  ValidWay;
   logic [NUMWAYS-1:0]  DirtyWay;
   logic                WBAck;
   logic [SETLEN-1:0]   FlushAdr;
   logic [NUMWAYS-1:0]  FlushWay;
   logic                SelFlush;
   logic                WBReq;
   logic                ClearDirty;
   logic                ClearValid;
   logic                Busy;
   logic                FlushDone;

   modport master (
      input  FlushReq, InvalidateReq, Stall, ValidWay, DirtyWay, WBAck,
      output FlushAdr, FlushWay, SelFlush, WBReq, ClearDirty, ClearValid, Busy, FlushDone
   );

   modport slave (
      output FlushReq, InvalidateReq, Stall, ValidWay, DirtyWay, WBAck,
      input  FlushAdr, FlushWay, SelFlush, WBReq, ClearDirty, ClearValid, Busy, FlushDone
   );
endinterface

// File: rtl/cache_flush_ctrl.sv
// Walks every (set, way) of the cache on flush/invalidate, writing back dirty
// valid lines via req/ack and clearing dirty/valid bits as it goes.
module cache_flush_ctrl #(
   parameter int unsigned NUMWAYS  = 4,
   parameter int unsigned SETLEN   = 9,
   parameter int unsigned NUMLINES = 128
) (
   input logic                clk,
   input logic                reset,
   cache_flush_ctrl_if.master bus
);

   localparam int unsigned WAYW = (NUMWAYS  > 1) ? $clog2(NUMWAYS)  : 1;
   localparam int unsigned SETW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;
   localparam logic [WAYW-1:0] LAST_WAY = WAYW'(NUMWAYS - 1);
   localparam logic [SETW-1:0] LAST_SET = SETW'(NUMLINES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CHECK = 3'd2,
      S_WB    = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [SETW-1:0] r_set;
   logic [SETW-1:0] w_set_nxt;
   logic [WAYW-1:0] r_way;
   logic [WAYW-1:0] w_way_nxt;
   logic            r_inv;
   logic            w_inv_nxt;
   logic            w_wbreq;
   logic            w_clr_dirty;
   logic            w_clr_valid;
   logic            w_done;
   logic            w_line_wb;
   logic            w_last;

   // Line needs a writeback only when it is both valid and dirty.
   assign w_line_wb = bus.ValidWay[r_way] & bus.DirtyWay[r_way];
   assign w_last    = (r_set == LAST_SET) && (r_way == LAST_WAY);

   // State and walk counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_set   <= '0;
         r_way   <= '0;
         r_inv   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_set   <= w_set_nxt;
         r_way   <= w_way_nxt;
         r_inv   <= w_inv_nxt;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      w_state_nxt = r_state;
      w_set_nxt   = r_set;
      w_way_nxt   = r_way;
      w_inv_nxt   = r_inv;
      w_wbreq     = 1'b0;
      w_clr_dirty = 1'b0;
      w_clr_valid = 1'b0;
      w_done      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if ((bus.FlushReq | bus.InvalidateReq) & ~bus.Stall) begin
               w_set_nxt   = '0;
               w_way_nxt   = '0;
               w_inv_nxt   = bus.InvalidateReq;
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (!bus.Stall) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (!bus.Stall) w_state_nxt = w_line_wb ? S_WB : S_NEXT;
         end
         S_WB: begin
            // Writeback handshake ignores Stall: the request must stay up.
            w_wbreq = 1'b1;
            if (bus.WBAck) begin
               w_clr_dirty = 1'b1;
               w_state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (!bus.Stall) begin
               w_clr_valid = r_inv;
               w_way_nxt   = WAYW'(r_way + 1'b1);
               if (r_way == LAST_WAY) w_set_nxt = SETW'(r_set + 1'b1);
               if (w_last) begin
                  w_set_nxt   = '0;
                  w_way_nxt   = '0;
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_READ;
               end
            end
         end
         S_DONE: begin
            if (!bus.Stall) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.FlushAdr   = SETLEN'(r_set);
   assign bus.FlushWay   = {{(NUMWAYS-1){1'b0}}, 1'b1} << r_way;
   assign bus.SelFlush   = (r_state != S_IDLE);
   assign bus.Busy       = (r_state != S_IDLE);
   assign bus.WBReq      = w_wbreq;
   assign bus.ClearDirty = w_clr_dirty;
   assign bus.ClearValid = w_clr_valid;
   assign bus.FlushDone  = w_done;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Self-checking bench for cache_flush_ctrl: vector table, hand sequences for
// stall/reset corners, and randomized cache contents against a line-level model.
module tb_cache_flush_ctrl;

   localparam int NW = 4;
   localparam int NL = 4;
   localparam int SL = 9;
   localparam int NLINE = NW * NL;
   localparam int BASE_DONE = 3 * NLINE + 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cache_flush_ctrl_if #(.NUMWAYS(NW), .SETLEN(SL)) bus ();

   cache_flush_ctrl #(.NUMWAYS(NW), .SETLEN(SL), .NUMLINES(NL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   bit valid_m [NL][NW];
   bit dirty_m [NL][NW];
   bit exp_valid [NL][NW];
   bit exp_dirty [NL][NW];
   int ack_q[$];
   int exp_wb[$];
   int got_wb[$];

   int done_cyc, wb_cyc, cd_cnt, cv_cnt, done_pulses, vis_n;
   bit vis_ok, cv_ok, busy_ok;

   typedef struct {
      bit fl; bit iv; bit hold;
      int dset; int dway; bit dvalid; int dly;
      int exp_done; int exp_wbc; int exp_cv;
   } vec_t;
   vec_t vt [7];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int way_idx(input logic [NW-1:0] oh);
      int r = -1;
      int n = 0;
      for (int i = 0; i < NW; i++) if (oh[i]) begin r = i; n++; end
      return (n == 1) ? r : -1;
   endfunction

   task automatic fill(input bit v, input bit d);
      for (int s = 0; s < NL; s++)
         for (int w = 0; w < NW; w++) begin
            valid_m[s][w] = v;
            dirty_m[s][w] = d;
         end
   endtask

   // Drives one flush run, playing the role of cache arrays and writeback bus.
   task automatic run_flush(input bit fl, input bit iv, input bit hold,
                            input logic [127:0] stall_vec, input bit abort_on_wb);
      int cyc, wb_wait, prev_adr, a, w, t, last_t;
      bit fin;
      bit aborted;
      done_cyc = -1; wb_cyc = 0; cd_cnt = 0; cv_cnt = 0; done_pulses = 0; vis_n = 0;
      vis_ok = 1; cv_ok = 1; busy_ok = 1; aborted = 0;
      got_wb.delete();
      @(negedge clk);
      bus.FlushReq = fl; bus.InvalidateReq = iv; bus.Stall = 1'b0; bus.WBAck = 1'b0;
      prev_adr = int'(bus.FlushAdr) % NL;
      cyc = 0; fin = 0; wb_wait = 0; last_t = -1;
      while (!fin && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (!hold) begin bus.FlushReq = 1'b0; bus.InvalidateReq = 1'b0; end
         bus.Stall = (cyc < 128) ? stall_vec[cyc] : 1'b0;
         for (int i = 0; i < NW; i++) begin
            bus.ValidWay[i] = valid_m[prev_adr][i];
            bus.DirtyWay[i] = dirty_m[prev_adr][i];
         end
         prev_adr = int'(bus.FlushAdr) % NL;
         if (bus.WBReq) begin
            if (ack_q.size() == 0 || wb_wait >= ack_q[0]) begin
               bus.WBAck = 1'b1;
               wb_wait = 0;
               if (ack_q.size() > 0) void'(ack_q.pop_front());
            end else begin
               bus.WBAck = 1'b0;
               wb_wait++;
            end
         end else begin
            bus.WBAck = 1'b0;
         end
         #1;
         if (!(bus.Busy && bus.SelFlush)) busy_ok = 0;
         if (bus.WBReq) wb_cyc++;
         w = way_idx(bus.FlushWay);
         a = int'(bus.FlushAdr);
         if (bus.ClearDirty) begin
            cd_cnt++;
            got_wb.push_back((w < 0) ? -1 : a * NW + w);
            if (a < NL && w >= 0) dirty_m[a][w] = 1'b0;
         end
         if (bus.ClearValid) begin
            if (w < 0 || a * NW + w != cv_cnt) cv_ok = 0;
            cv_cnt++;
            if (a < NL && w >= 0) valid_m[a][w] = 1'b0;
         end
         if (bus.Busy && !bus.FlushDone) begin
            t = (w < 0) ? -2 : a * NW + w;
            if (t != last_t) begin
               if (t != vis_n) vis_ok = 0;
               vis_n++;
               last_t = t;
            end
         end
         if (bus.FlushDone) begin
            done_pulses++;
            done_cyc = cyc;
            fin = 1;
            bus.FlushReq = 1'b0; bus.InvalidateReq = 1'b0;
         end
         if (abort_on_wb && bus.WBReq) begin
            #2 reset = 1'b0;
            #1;
            chk("abort_wbreq", int'(bus.WBReq), 0);
            chk("abort_busy", int'(bus.Busy), 0);
            chk("abort_selflush", int'(bus.SelFlush), 0);
            chk("abort_flushadr", int'(bus.FlushAdr), 0);
            aborted = 1;
            fin = 1;
         end
      end
      chk("done_within_budget", int'(fin), 1);
      bus.WBAck = 1'b0; bus.Stall = 1'b0;
      bus.FlushReq = 1'b0; bus.InvalidateReq = 1'b0;
      @(negedge clk);
      if (aborted) begin
         chk("reset_holds_idle", int'(bus.Busy), 0);
         reset = 1'b1;
      end else begin
         chk("done_single_pulse", int'(bus.FlushDone), 0);
         chk("idle_after_done", int'(bus.Busy), 0);
      end
   endtask

   // Line-level reference: which lines get written back, how long it takes, end state.
   task automatic model(input bit iv, input bit rand_dly, input int fixed_dly, output int exp_done);
      int d;
      exp_done = BASE_DONE;
      exp_wb.delete();
      ack_q.delete();
      for (int s = 0; s < NL; s++)
         for (int w = 0; w < NW; w++) begin
            exp_valid[s][w] = iv ? 1'b0 : valid_m[s][w];
            exp_dirty[s][w] = dirty_m[s][w];
            if (valid_m[s][w] && dirty_m[s][w]) begin
               d = rand_dly ? int'($urandom_range(0, 3)) : fixed_dly;
               exp_wb.push_back(s * NW + w);
               ack_q.push_back(d);
               exp_done += d + 1;
               exp_dirty[s][w] = 1'b0;
            end
         end
   endtask

   function automatic int wb_list_ok();
      if (got_wb.size() != exp_wb.size()) return 0;
      foreach (exp_wb[i]) if (got_wb[i] != exp_wb[i]) return 0;
      return 1;
   endfunction

   function automatic int array_mismatch();
      int n = 0;
      for (int s = 0; s < NL; s++)
         for (int w = 0; w < NW; w++)
            if (valid_m[s][w] != exp_valid[s][w] || dirty_m[s][w] != exp_dirty[s][w]) n++;
      return n;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int ed;
      bit fl, iv;
      logic [127:0] sv;
      bus.FlushReq = 1'b0; bus.InvalidateReq = 1'b0; bus.Stall = 1'b0;
      bus.ValidWay = '0; bus.DirtyWay = '0; bus.WBAck = 1'b0;
      fill(1'b1, 1'b0);

      #3;
      chk("rst_flushadr", int'(bus.FlushAdr), 0);
      chk("rst_flushway", int'(bus.FlushWay), 1);
      chk("rst_wbreq", int'(bus.WBReq), 0);
      chk("rst_cleardirty", int'(bus.ClearDirty), 0);
      chk("rst_clearvalid", int'(bus.ClearValid), 0);
      chk("rst_busy", int'(bus.Busy), 0);
      chk("rst_selflush", int'(bus.SelFlush), 0);
      chk("rst_flushdone", int'(bus.FlushDone), 0);
      #9 reset = 1'b1;

      //        fl iv hold dset dway dvalid dly  done          wbc cv
      vt[0] = '{1, 0, 0,  -1,  0,   1,     0,  BASE_DONE,     0,  0};
      vt[1] = '{1, 0, 0,   2,  1,   1,     5,  BASE_DONE + 6, 6,  0};
      vt[2] = '{0, 1, 0,  -1,  0,   1,     0,  BASE_DONE,     0,  16};
      vt[3] = '{1, 1, 0,  -1,  0,   1,     0,  BASE_DONE,     0,  16};
      vt[4] = '{1, 0, 0,   2,  1,   0,     0,  BASE_DONE,     0,  0};
      vt[5] = '{0, 1, 0,   0,  0,   1,     0,  BASE_DONE + 1, 1,  16};
      vt[6] = '{1, 0, 1,   3,  3,   1,     2,  BASE_DONE + 3, 3,  0};

      foreach (vt[k]) begin
         fill(1'b1, 1'b0);
         ack_q.delete();
         if (vt[k].dset >= 0) begin
            dirty_m[vt[k].dset][vt[k].dway] = 1'b1;
            valid_m[vt[k].dset][vt[k].dway] = vt[k].dvalid;
            ack_q.push_back(vt[k].dly);
         end
         run_flush(vt[k].fl, vt[k].iv, vt[k].hold, '0, 1'b0);
         chk($sformatf("v%0d_done_cycle", k), done_cyc, vt[k].exp_done);
         chk($sformatf("v%0d_wbreq_cycles", k), wb_cyc, vt[k].exp_wbc);
         chk($sformatf("v%0d_cleardirty", k), cd_cnt, (vt[k].exp_wbc > 0) ? 1 : 0);
         chk($sformatf("v%0d_clearvalid", k), cv_cnt, vt[k].exp_cv);
         chk($sformatf("v%0d_clearvalid_order", k), int'(cv_ok), 1);
         chk($sformatf("v%0d_visit_order", k), (vis_ok && vis_n == NLINE) ? 1 : 0, 1);
         chk($sformatf("v%0d_busy_selflush", k), int'(busy_ok), 1);
         chk($sformatf("v%0d_done_pulses", k), done_pulses, 1);
         if (vt[k].exp_wbc > 0)
            chk($sformatf("v%0d_wb_line", k), (got_wb.size() > 0) ? got_wb[0] : -1,
                vt[k].dset * NW + vt[k].dway);
      end

      // Stall 3 cycles in CHECK of line (2,1) and 3 cycles inside its writeback.
      fill(1'b1, 1'b0);
      dirty_m[2][1] = 1'b1;
      ack_q.delete();
      ack_q.push_back(5);
      sv = '0;
      sv[29] = 1'b1; sv[30] = 1'b1; sv[31] = 1'b1;
      sv[34] = 1'b1; sv[35] = 1'b1; sv[36] = 1'b1;
      run_flush(1'b1, 1'b0, 1'b0, sv, 1'b0);
      chk("stall_done_cycle", done_cyc, BASE_DONE + 6 + 3);
      chk("stall_wbreq_cycles", wb_cyc, 6);
      chk("stall_cleardirty", cd_cnt, 1);
      chk("stall_wb_line", (got_wb.size() > 0) ? got_wb[0] : -1, 2 * NW + 1);

      // Reset mid-writeback, then a fresh flush restarts from set 0 way 0.
      fill(1'b1, 1'b0);
      dirty_m[1][2] = 1'b1;
      ack_q.delete();
      ack_q.push_back(10);
      run_flush(1'b1, 1'b0, 1'b0, '0, 1'b1);
      chk("abort_no_cleardirty", cd_cnt, 0);
      model(1'b0, 1'b0, 1, ed);
      run_flush(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("restart_done_cycle", done_cyc, ed);
      chk("restart_visit_order", (vis_ok && vis_n == NLINE) ? 1 : 0, 1);
      chk("restart_wb_list", wb_list_ok(), 1);

      // Random cache contents, random mode and ack latencies.
      for (int r = 0; r < 20; r++) begin
         for (int s = 0; s < NL; s++)
            for (int w = 0; w < NW; w++) begin
               valid_m[s][w] = 1'($urandom_range(0, 1));
               dirty_m[s][w] = 1'($urandom_range(0, 1));
            end
         iv = 1'($urandom_range(0, 1));
         fl = iv ? 1'($urandom_range(0, 1)) : 1'b1;
         model(iv, 1'b1, 0, ed);
         run_flush(fl, iv, 1'b0, '0, 1'b0);
         chk($sformatf("rnd%0d_done_cycle", r), done_cyc, ed);
         chk($sformatf("rnd%0d_wb_list", r), wb_list_ok(), 1);
         chk($sformatf("rnd%0d_clearvalid", r), cv_cnt, iv ? NLINE : 0);
         chk($sformatf("rnd%0d_array_state", r), array_mismatch(), 0);
         chk($sformatf("rnd%0d_visit_order", r), (vis_ok && vis_n == NLINE) ? 1 : 0, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_flush_ctrl.md
Name: cache_flush_ctrl

Overview:
- Sequencer that walks every (set, way) of a set-associative cache on a flush or invalidate request. It writes back dirty valid lines through a req/ack handshake, clears dirty and optionally valid bits, then signals completion.
- Sits beside the cache tag/data arrays and the replacement logic.
- While it is busy, it drives the flush address and way into the array address mux.

Parameters:
NUMWAYS, 4, ways per set; power of 2, >=2
SETLEN, 9, set index width
NUMLINES, 128, sets per way; power of 2, <= 2**SETLEN

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
FlushReq  input  1  start flush (write back dirty lines, keep valid)
InvalidateReq  input  1  start flush plus invalidate of every line
Stall  input  1  freeze sequencing for this cycle
ValidWay  input  NUMWAYS  valid bits of set at FlushAdr; arrives 1 cycle after address
DirtyWay  input  NUMWAYS  dirty bits of set at FlushAdr; same timing as ValidWay
WBAck  input  1  bus accepted current writeback
FlushAdr  output  SETLEN  set index being visited
FlushWay  output  NUMWAYS  one-hot way being visited
SelFlush  output  1  array address mux selects FlushAdr
WBReq  output  1  request writeback of line (FlushAdr, FlushWay)
ClearDirty  output  1  one-cycle pulse: clear dirty bit of (FlushAdr, FlushWay)
ClearValid  output  1  one-cycle pulse: clear valid bit of (FlushAdr, FlushWay)
Busy  output  1  sequencer not idle
FlushDone  output  1  one-cycle completion pulse

Behaviour:
- States: IDLE, READ, CHECK, WB, NEXT, DONE.
- Internal set counter: log2(NUMLINES) bits, zero-extended to FlushAdr.
- Internal way counter: log2(NUMWAYS) bits, decoded to FlushWay.
- Inv mode flag latched at start.
- Reset (async, reset=0): state IDLE, counters 0, Inv=0.
- Outputs while in reset: FlushAdr=0, FlushWay=0...01, WBReq=0, ClearDirty=0, ClearValid=0, Busy=0, SelFlush=0, FlushDone=0.
- IDLE: when (FlushReq | InvalidateReq) & ~Stall:
  - counters cleared;
  - Inv <= InvalidateReq (both requests together count as invalidate);
  - next state READ.
- READ: array read of FlushAdr issued; next state CHECK.
- CHECK: sample ValidWay and DirtyWay at the FlushWay position.
  - If valid & dirty: go to WB.
  - Otherwise: go to NEXT.
- WB:
  - WBReq held high until the cycle WBAck=1.
  - That cycle: ClearDirty=1; next state NEXT.
  - WBAck outside WB is ignored.
  - Stall does not drop WBReq; an ack during Stall is still honoured.
- NEXT:
  - ClearValid=Inv; the clear targets the current line before the counters advance.
  - Then the way counter increments. When it wraps from NUMWAYS-1 to 0, the set counter increments.
  - If set=NUMLINES-1 and way=NUMWAYS-1 before the increment: go to DONE, counters wrap to 0.
  - Otherwise: go to READ.
- DONE: FlushDone=1 for exactly one cycle; next state IDLE.
- Stall=1 in READ, CHECK, NEXT or DONE:
  - state and counters hold;
  - ClearDirty, ClearValid and FlushDone are suppressed;
  - CHECK resamples on the next unstalled cycle.
- Busy=1 and SelFlush=1 in every state except IDLE.
- FlushReq and InvalidateReq are ignored while Busy; they are not queued.
- Latency, no stalls, no dirty lines: entering READ until DONE takes 3*NUMWAYS*NUMLINES cycles.
- Each dirty line adds (cycles in WB).
- Reset asserted mid-sequence aborts immediately:
  - no further writebacks;
  - partial clears already performed stand.

Test Plan:
- NUMWAYS=4, NUMLINES=4, all lines clean, FlushReq pulse at edge 0 -> Busy=1 from edge 1; exactly 16 READ visits in order (set0 way0..3, set1 ...); FlushDone is a single pulse at edge 50; no WBReq, ClearDirty or ClearValid.
- Dirty+valid only at set 2, way 1; WBAck held low 5 cycles then 1 -> WBReq high 6 cycles with FlushAdr=2, FlushWay=4'b0010; ClearDirty for 1 cycle on the ack edge; FlushDone 6 cycles later than in the clean case.
- InvalidateReq with all lines valid and clean -> 16 ClearValid pulses, one per (set, way), no WBReq; FlushReq+InvalidateReq in the same cycle behaves identically.
- Line dirty but invalid (ValidWay bit 0, DirtyWay bit 1) -> no WBReq for that line.
- Stall held 3 cycles during CHECK and 3 cycles during WB -> CHECK result is taken after the stall; WBReq stays high throughout; FlushDone is delayed exactly 3 cycles by the CHECK stall plus any extra ack wait.
- reset=0 asserted while WBReq=1 -> WBReq, Busy and SelFlush go to 0 asynchronously before the next clock edge; after release, a new FlushReq restarts at set 0, way 0.
